// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO write and read controllers.
// Functions work on a wide container; callers size-cast to their pointer width.
package fifo_pkg;

  localparam int unsigned MAX_PTR_W = 32;

  typedef logic [MAX_PTR_W-1:0] wide_t;

  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

  function automatic wide_t bin2gray(input wide_t b);
    return b ^ (b >> 32'd1);
  endfunction

  function automatic wide_t gray2bin(input wide_t g);
    wide_t b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted.
  function automatic logic gray_full_match(input wide_t wgray, input wide_t rgray,
                                           input int unsigned pw);
    wide_t mask;
    wide_t inv;
    mask = (wide_t'(32'd1) << pw) - wide_t'(32'd1);
    inv  = rgray ^ (wide_t'(32'd3) << (pw - 32'd2));
    return ((wgray ^ inv) & mask) == wide_t'(32'd0);
  endfunction

endpackage

// File: rtl/fifo_wr_ptr_ctrl_if.sv
// Producer-side bus of the FIFO write-pointer controller.
interface fifo_wr_ptr_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 4
) ();

  logic                  wr_en;
  logic [ADDR_WIDTH:0]   rptr_sync;
  logic                  ovf_clr;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wr_accept;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  overflow;

  modport master (
    output wr_en, rptr_sync, ovf_clr,
    input  wptr_gray, waddr, wr_accept, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  wr_en, rptr_sync, ovf_clr,
    output wptr_gray, waddr, wr_accept, full, almost_full, wr_level, overflow
  );

endinterface

// File: rtl/gray_cnt.sv
// Registered binary + Gray pointer with increment enable; the Gray output is a bare flop.
module gray_cnt
  import fifo_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-2:0] addr,
  output logic [W-1:0] gray,
  output logic [W-1:0] bin_next,
  output logic [W-1:0] gray_next
);

  logic [W-1:0] bin_r;
  logic [W-1:0] gray_r;

  // next binary and Gray values from the current pointer
  always_comb begin
    bin_next  = bin_r + W'(inc);
    gray_next = W'(bin2gray(wide_t'(bin_next)));
  end

  // pointer registers, reloaded every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_r  <= '0;
      gray_r <= '0;
    end else begin
      bin_r  <= bin_next;
      gray_r <= gray_next;
    end
  end

  assign addr = bin_r[W-2:0];
  assign gray = gray_r;

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer/status controller: owns the write pointer, publishes its Gray form,
// and derives full / almost_full / level / overflow against the synchronized read pointer.
module fifo_wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AFULL_THRESH = 14
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_ptr_ctrl_if.slave bus
);

  localparam int unsigned PW = ptr_width(ADDR_WIDTH);

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t AFULL_P = ptr_t'(AFULL_THRESH);

  logic                  wr_accept_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  ptr_t                  wgray_s;
  ptr_t                  wbin_next_s;
  ptr_t                  wgray_next_s;
  ptr_t                  rbin_s;
  ptr_t                  level_next_s;
  logic                  full_r;
  logic                  afull_r;
  ptr_t                  level_r;
  logic                  ovf_r;

  assign wr_accept_s = bus.wr_en & ~full_r;

  gray_cnt #(.W(PW)) u_wptr (
    .clk       (clk),
    .rst       (rst),
    .inc       (wr_accept_s),
    .addr      (waddr_s),
    .gray      (wgray_s),
    .bin_next  (wbin_next_s),
    .gray_next (wgray_next_s)
  );

  // occupancy after this edge, measured against the (possibly stale) read pointer
  always_comb begin
    rbin_s       = ptr_t'(gray2bin(wide_t'(bus.rptr_sync)));
    level_next_s = wbin_next_s - rbin_s;
  end

  // status flags and level, computed from the same next-state as the pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r  <= 1'b0;
      afull_r <= 1'b0;
      level_r <= '0;
    end else begin
      full_r  <= gray_full_match(wide_t'(wgray_next_s), wide_t'(bus.rptr_sync), PW);
      afull_r <= (level_next_s >= AFULL_P);
      level_r <= level_next_s;
    end
  end

  // sticky overflow; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (bus.wr_en && full_r) begin
      ovf_r <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign bus.wptr_gray   = wgray_s;
  assign bus.waddr       = waddr_s;
  assign bus.wr_accept   = wr_accept_s;
  assign bus.full        = full_r;
  assign bus.almost_full = afull_r;
  assign bus.wr_level    = level_r;
  assign bus.overflow    = ovf_r;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Self-checking bench for fifo_wr_ptr_ctrl: vector table, hand sequences, and random traffic
// compared against an occupancy-count model.
module tb_fifo_wr_ptr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fifo_wr_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wr_ptr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(AFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       we;
    int         r;
    logic       clr;
    logic       acc;
    logic       full;
    logic       afull;
    int         level;
    logic       ovf;
    logic [4:0] gray;
  } vec_t;

  vec_t vt[$];

  int checks = 0;
  int errors = 0;

  // Model: total writes accepted, total reads seen via rptr_sync, and registered flags.
  int   m_w;
  int   m_r;
  int   m_level;
  logic m_full;
  logic m_afull;
  logic m_ovf;
  int   hist[$];

  function automatic logic [4:0] gray_of(input int n);
    int b;
    b = n % 32;
    return 5'(b ^ (b >> 1));
  endfunction

  function automatic vec_t mk(input logic we, input int r, input logic clr, input logic acc,
                              input logic full, input logic afull, input int level,
                              input logic ovf, input logic [4:0] gray);
    vec_t v;
    v.we = we; v.r = r; v.clr = clr; v.acc = acc; v.full = full;
    v.afull = afull; v.level = level; v.ovf = ovf; v.gray = gray;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_r = 0; m_level = 0;
    m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
    hist.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gray"},  bus.wptr_gray,   0);
    chk({tag, "_waddr"}, bus.waddr,       0);
    chk({tag, "_full"},  bus.full,        0);
    chk({tag, "_afull"}, bus.almost_full, 0);
    chk({tag, "_level"}, bus.wr_level,    0);
    chk({tag, "_ovf"},   bus.overflow,    0);
  endtask

  // One clock: drive at negedge, check combinational outputs, take the edge, check registers.
  task automatic step(input logic we, input logic clr, output logic acc_seen);
    logic       acc;
    logic [4:0] g_before;
    int         lvl;
    bus.wr_en     = we;
    bus.rptr_sync = gray_of(m_r);
    bus.ovf_clr   = clr;
    #1;
    acc      = we && !m_full;
    acc_seen = bus.wr_accept;
    chk("wr_accept", bus.wr_accept, acc);
    chk("waddr", bus.waddr, m_w % DEPTH);
    g_before = bus.wptr_gray;
    @(posedge clk);
    m_ovf = (we && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    if (acc) m_w++;
    lvl     = ((m_w - m_r) % 32 + 32) % 32;
    m_level = lvl;
    m_full  = (lvl == DEPTH);
    m_afull = (lvl >= AFT);
    hist.push_back(m_w);
    @(negedge clk);
    chk("full", bus.full, m_full);
    chk("almost_full", bus.almost_full, m_afull);
    chk("wr_level", bus.wr_level, m_level);
    chk("overflow", bus.overflow, m_ovf);
    chk("wptr_gray", bus.wptr_gray, gray_of(m_w));
    chk("gray_onebit", $countones(g_before ^ bus.wptr_gray), acc ? 1 : 0);
  endtask

  // Reset asserted mid-cycle (no clock edge in between); released on a negedge.
  task automatic do_reset(input logic keep_wr, input string tag);
    bus.wr_en   = keep_wr;
    bus.ovf_clr = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_zero(tag);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Advance the read pointer by at most one, never past the write count three cycles back.
  task automatic lag_read(input logic force_adv);
    if (hist.size() >= 3 && m_r < hist[hist.size()-3] && (force_adv || $urandom_range(0, 2) != 0))
      m_r++;
  endtask

  logic acc_s;

  initial begin
    bus.wr_en = 1'b0; bus.rptr_sync = '0; bus.ovf_clr = 1'b0;
    model_reset();

    // Reset and idle
    @(negedge clk);
    do_reset(1'b0, "rst");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, acc_s);

    // Vector table: fill, overflow/clear, drain
    for (int k = 1; k <= DEPTH; k++)
      vt.push_back(mk(1'b1, 0, 1'b0, 1'b1, k == DEPTH, k >= AFT, k, 1'b0, gray_of(k)));
    vt.push_back(mk(1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b1, 5'b11000));
    vt.push_back(mk(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 16, 1'b0, 5'b11000));
    vt.push_back(mk(1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 16, 1'b1, 5'b11000));
    vt.push_back(mk(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 16, 1'b0, 5'b11000));
    vt.push_back(mk(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 15, 1'b0, 5'b11000));
    vt.push_back(mk(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 14, 1'b0, 5'b11000));
    vt.push_back(mk(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 13, 1'b0, 5'b11000));
    for (int i = 0; i < vt.size(); i++) begin
      m_r = vt[i].r;
      step(vt[i].we, vt[i].clr, acc_s);
      chk($sformatf("tbl%0d_acc", i),   acc_s,           vt[i].acc);
      chk($sformatf("tbl%0d_full", i),  bus.full,        vt[i].full);
      chk($sformatf("tbl%0d_afull", i), bus.almost_full, vt[i].afull);
      chk($sformatf("tbl%0d_level", i), bus.wr_level,    vt[i].level);
      chk($sformatf("tbl%0d_ovf", i),   bus.overflow,    vt[i].ovf);
      chk($sformatf("tbl%0d_gray", i),  bus.wptr_gray,   vt[i].gray);
    end

    // Refill to full, then a read arrives together with a write request
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, acc_s);
    chk("refill_full", bus.full, 1);
    m_r = 4;
    step(1'b1, 1'b0, acc_s);
    chk("simul_no_accept", acc_s, 0);
    chk("simul_full_clears", bus.full, 0);
    chk("simul_level", bus.wr_level, 15);
    step(1'b1, 1'b0, acc_s);
    chk("simul_accept_next", acc_s, 1);

    // Wrap: 40 writes with the read pointer trailing
    do_reset(1'b0, "rst2");
    for (int i = 0; i < 40; i++) begin
      lag_read(1'b1);
      step(1'b1, 1'b0, acc_s);
      chk("wrap_nofull", bus.full, 0);
    end
    chk("wrap_count", m_w, 40);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      lag_read(1'b0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, acc_s);
    end

    // Reset in the middle of a write burst at level 9
    do_reset(1'b0, "rst3");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, acc_s);
    chk("burst_level9", bus.wr_level, 9);
    do_reset(1'b1, "rst_mid");
    bus.wr_en = 1'b1;
    #1;
    chk("post_rst_waddr", bus.waddr, 0);
    step(1'b1, 1'b0, acc_s);
    chk("post_rst_level", bus.wr_level, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ptr_ctrl.md
Name: fifo_wr_ptr_ctrl

Overview:
Write-domain pointer and status controller for the async FIFO. It is the source end of the pointer crossing.
- Owns the binary write pointer and drives the memory write address/enable.
- Publishes a registered Gray-coded write pointer for the read-domain `synchronizer`.
- Compares its own pointer against the already-synchronized Gray read pointer to produce full, almost_full, fill level and a sticky overflow flag.

Parameters:
- ADDR_WIDTH, 4: FIFO depth is 2**ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits. Must be >= 2.
- AFULL_THRESH, 14: almost_full asserts when fill level >= this value. Legal range 1 .. 2**ADDR_WIDTH.

Ports:
- clk  in  1  write-domain clock
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  write request from producer
- rptr_sync  in  ADDR_WIDTH+1  Gray read pointer, already synchronized into clk domain
- ovf_clr  in  1  clears the overflow flag
- wptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer
- waddr  out  ADDR_WIDTH  memory write address, equal to wbin[ADDR_WIDTH-1:0]
- wr_accept  out  1  memory write enable, equal to wr_en & ~full (combinational)
- full  out  1  registered full flag
- almost_full  out  1  registered almost-full flag
- wr_level  out  ADDR_WIDTH+1  registered fill level, range 0..2**ADDR_WIDTH
- overflow  out  1  sticky flag: a write was attempted while full

Behaviour:
- Reset (async, immediate): wbin=0, wptr_gray=0, full=0, almost_full=0, wr_level=0, overflow=0. waddr reads 0 as soon as reset asserts.
- Next-pointer calculation:
  - wbin_next = wbin + wr_accept, modulo 2**(ADDR_WIDTH+1). Wrap from all-ones to 0 is natural.
  - gray_next = wbin_next ^ (wbin_next >> 1).
  - Both wbin and wptr_gray are flops loaded every cycle from these values.
- wptr_gray requirements:
  - Must come straight from a flop, with no combinational logic after the register.
  - Changes at most one bit per clk edge, so the receiving synchronizer never samples a multi-bit transition.
- Full:
  - full <= (gray_next == {~rptr_sync[A:A-1], rptr_sync[A-2:0]}), where A = ADDR_WIDTH.
  - Asserts on the edge that accepts the write filling the last slot, i.e. visible in the cycle after that write.
- Level:
  - rbin = Gray-to-binary of rptr_sync (combinational XOR-prefix).
  - wr_level <= wbin_next - rbin, modulo 2**(A+1).
  - almost_full <= (wbin_next - rbin) >= AFULL_THRESH.
- Conservatism:
  - rptr_sync lags the true read pointer by the synchronizer latency (3 clk).
  - full, almost_full and wr_level may therefore stay high or report too large for that long after reads.
  - They must never report less than the true occupancy. No overwrite is possible.
- Write while full:
  - wr_accept=0; wbin and wptr_gray hold; memory is not written.
  - overflow <= 1 on the next edge.
- Overflow clear:
  - ovf_clr clears overflow on the next edge.
  - If a set condition (wr_en & full) and ovf_clr occur in the same cycle, set wins: overflow stays 1.
- Simultaneous write and rptr_sync change: both are folded into the same next-state computation. Example: full with a read just synchronized plus wr_en held gives full=1 for that cycle and no accept; full clears next cycle.
- No internal state machine beyond the pointer, flag and level registers. Throughput is one write per clock while not full.
- Input assumption: rptr_sync is a valid Gray code that changes by at most one code step per clk. Multi-step jumps are tolerated functionally but must still never cause an underestimate of level.

Decomposition:
- Shared package fifo_pkg holds:
  - the ptr_t width derivation (ADDR_WIDTH+1);
  - functions bin2gray and gray2bin;
  - the full-compare helper (top-two-bit inversion).
  The read-side empty controller reuses the same package.
- One natural sub-module: gray_cnt, the registered binary+Gray counter with increment enable and async reset. It is shared with the future read-pointer controller.
- Flag and level logic stays in fifo_wr_ptr_ctrl.

Test Plan:
(Defaults: ADDR_WIDTH=4, AFULL_THRESH=14.)
1. Reset: assert rst mid-cycle -> all outputs 0 immediately, with no clk edge needed. Release, wr_en=0 -> outputs stay 0.
2. Fill: rptr_sync=0, 16 consecutive wr_en -> wptr_gray steps 00000, 00001, 00011, 00010, 00110, ...; after the 14th write almost_full=1; after the 16th write full=1, wr_level=16, wptr_gray=11000.
3. Overflow: while full, wr_en=1 for 1 cycle -> wr_accept=0, wptr_gray holds 11000, overflow=1. ovf_clr alone -> overflow=0. wr_en and ovf_clr together while full -> overflow=1.
4. Drain: from full, set rptr_sync=00001 (read ptr 1) -> next cycle full=0, wr_level=15, almost_full=1. rptr_sync=00011 -> wr_level=14. rptr_sync=00010 -> wr_level=13, almost_full=0.
5. Wrap: 40 writes with rptr_sync tracking wptr 3 cycles behind -> wbin wraps 31->0 (wptr_gray 10000->00000). full never asserts. Every wptr_gray change is exactly one bit (checked by an assertion).
6. Reset mid-burst: rst during a run of writes at level 9 -> level, flags and pointers go to 0 asynchronously. First write after release uses waddr=0.
